// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types and defaults for the two-port memory arbiter
package memory_arbiter_pkg;

  localparam int MEMORY_WIDTH = 32;
  localparam int ARB_TIMEOUT  = 64;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SETUP   = 2'd1,
    ARB_STROBE  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/memory_arbiter_rr2.sv
// rtl/memory_arbiter_rr2.sv - two-way round-robin picker, combinational in req and last_grant
module arbiter_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  // req[1] is port D, req[0] is port I; a tie goes to whoever did not win last
  always_comb begin
    valid = |req;
    grant = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one strobe/ack memory between instruction and data ports
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WIDTH   = MEMORY_WIDTH,
  parameter int TIMEOUT = ARB_TIMEOUT,
  localparam int BYTES  = WIDTH / 8,
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              i_read_write,
  input  logic [BYTES-1:0]  i_byte_enable,
  input  logic [WIDTH-1:0]  i_data_in,
  output logic [WIDTH-1:0]  i_data_out,
  output logic              i_ack,
  output logic              i_error,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic              d_read_write,
  input  logic [BYTES-1:0]  d_byte_enable,
  input  logic [WIDTH-1:0]  d_data_in,
  output logic [WIDTH-1:0]  d_data_out,
  output logic              d_ack,
  output logic              d_error,
  output logic [31:0]       mem_addr,
  output logic              mem_enable,
  output logic              mem_read_write,
  output logic [BYTES-1:0]  mem_byte_enable,
  output logic [WIDTH-1:0]  mem_data_in,
  input  logic [WIDTH-1:0]  mem_data_out,
  input  logic              mem_ack
);

  arb_state_t    state;
  port_t         grant;
  port_t         last_grant;
  logic [CW-1:0] cnt;
  logic          pick_valid;
  logic          pick;

  arbiter_rr2 u_rr (
    .req        ({d_req, i_req}),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ARB_IDLE;
      grant           <= PORT_I;
      last_grant      <= PORT_I;
      cnt             <= '0;
      mem_enable      <= 1'b0;
      mem_read_write  <= 1'b1;
      mem_addr        <= '0;
      mem_byte_enable <= '0;
      mem_data_in     <= '0;
      i_ack           <= 1'b0;
      d_ack           <= 1'b0;
      i_error         <= 1'b0;
      d_error         <= 1'b0;
      i_data_out      <= '0;
      d_data_out      <= '0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_error <= 1'b0;
      d_error <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            mem_addr        <= pick ? d_addr        : i_addr;
            mem_read_write  <= pick ? d_read_write  : i_read_write;
            mem_byte_enable <= pick ? d_byte_enable : i_byte_enable;
            mem_data_in     <= pick ? d_data_in     : i_data_in;
            grant           <= port_t'(pick);
            last_grant      <= port_t'(pick);
            state           <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          // address and data have been stable for a full cycle before the strobe rises
          mem_enable <= 1'b1;
          cnt        <= '0;
          state      <= ARB_STROBE;
        end
        ARB_STROBE: begin
          if (mem_ack) begin
            if (mem_read_write) begin
              if (grant == PORT_D) d_data_out <= mem_data_out;
              else                 i_data_out <= mem_data_out;
            end
            if (grant == PORT_D) d_ack <= 1'b1;
            else                 i_ack <= 1'b1;
            mem_enable <= 1'b0;
            state      <= ARB_RELEASE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // abandoned strobe: complete with error, leave read data as it was
            if (grant == PORT_D) begin
              d_ack   <= 1'b1;
              d_error <= 1'b1;
            end else begin
              i_ack   <= 1'b1;
              i_error <= 1'b1;
            end
            mem_enable <= 1'b0;
            state      <= ARB_RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ARB_RELEASE: begin
          if (!mem_ack) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter with a latency-programmable memory stub
module tb_memory_arbiter;

  localparam int W  = 32;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_read_write, d_read_write;
  logic [3:0]  i_byte_enable, d_byte_enable;
  logic [31:0] i_data_in, d_data_in;
  logic [31:0] i_data_out, d_data_out;
  logic        i_ack, d_ack, i_error, d_error;
  logic [31:0] mem_addr;
  logic        mem_enable, mem_read_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_ack;

  always #5 clk = ~clk;

  memory_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_read_write(i_read_write),
    .i_byte_enable(i_byte_enable), .i_data_in(i_data_in),
    .i_data_out(i_data_out), .i_ack(i_ack), .i_error(i_error),
    .d_req(d_req), .d_addr(d_addr), .d_read_write(d_read_write),
    .d_byte_enable(d_byte_enable), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_ack(d_ack), .d_error(d_error),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_read_write(mem_read_write),
    .mem_byte_enable(mem_byte_enable), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ack(mem_ack)
  );

  // memory stub: acks mem_lat cycles after the strobe rises, drops ack with the strobe
  logic [31:0] mem_arr [64];
  int          mem_lat;
  bit          stuck;
  bit          mem_clear;
  int          en_cnt;

  always @(posedge clk) begin
    en_cnt <= mem_enable ? en_cnt + 1 : 0;
    if (mem_clear) begin
      for (int k = 0; k < 64; k++) mem_arr[k] <= '0;
    end else if (mem_enable && mem_ack && !mem_read_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) mem_arr[mem_addr[7:2]][b*8 +: 8] <= mem_data_in[b*8 +: 8];
    end
  end
  assign mem_ack      = mem_enable && !stuck && (en_cnt >= mem_lat);
  assign mem_data_out = mem_arr[mem_addr[7:2]];

  // reference model and bookkeeping
  logic [31:0] refmem [64];
  logic [31:0] hold [2];
  bit          last_g;
  int          errors, checks;
  bit          prev_en;
  logic [31:0] prev_addr;
  bit          f_rw [2];
  logic [31:0] f_addr [2];
  logic [3:0]  f_be [2];
  logic [31:0] f_wd [2];

  typedef struct {
    bit          p;
    bit          rw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          lat;
    logic [31:0] exp_out;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (i_ack || d_ack) chk("ack_exclusive", {31'd0, i_ack && d_ack}, 32'd0);
    if (mem_enable && prev_en) chk("addr_stable", mem_addr, prev_addr);
    prev_en   = mem_enable;
    prev_addr = mem_addr;
  endtask

  task automatic drive(input bit p, input bit req);
    if (p) begin
      d_req = req; d_read_write = f_rw[1]; d_addr = f_addr[1];
      d_byte_enable = f_be[1]; d_data_in = f_wd[1];
    end else begin
      i_req = req; i_read_write = f_rw[0]; i_addr = f_addr[0];
      i_byte_enable = f_be[0]; i_data_in = f_wd[0];
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic model_done(input bit p, input bit err);
    if (!err) begin
      if (f_rw[p]) hold[p] = refmem[f_addr[p][7:2]];
      else refmem[f_addr[p][7:2]] = merge(refmem[f_addr[p][7:2]], f_wd[p], f_be[p]);
    end
    last_g = p;
  endtask

  task automatic access(input bit p, input bit rw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int exp_lat, input bit exp_err);
    int n = 0;
    bit got = 0, other = 0;
    f_rw[p] = rw; f_addr[p] = addr; f_be[p] = be; f_wd[p] = wd;
    drive(p, 1'b1);
    while (!got && n < 40) begin
      tick();
      n++;
      if (p ? d_ack : i_ack) got = 1;
      if (p ? i_ack : d_ack) other = 1;
    end
    drive(p, 1'b0);
    chk("ack_latency", n, exp_lat);
    chk("other_port_ack", {31'd0, other}, 32'd0);
    chk("error_flag", {31'd0, p ? d_error : i_error}, {31'd0, exp_err});
    model_done(p, exp_err);
    chk("data_out", p ? d_data_out : i_data_out, hold[p]);
    tick();
  endtask

  initial begin
    int n, m, nacc;
    bit got, exp_p, seen;
    errors = 0; checks = 0; prev_en = 0; prev_addr = '0;
    stuck = 0; mem_lat = 0; mem_clear = 1; last_g = 0;
    hold[0] = '0; hold[1] = '0;
    for (int k = 0; k < 64; k++) refmem[k] = '0;
    for (int q = 0; q < 2; q++) begin f_rw[q] = 1; f_addr[q] = '0; f_be[q] = '0; f_wd[q] = '0; end
    reset = 1;
    drive(0, 0); drive(1, 0);
    repeat (3) tick();
    mem_clear = 0;
    reset = 0;
    tick();

    chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    chk("rst_mem_read_write", {31'd0, mem_read_write}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_byte_enable", {28'd0, mem_byte_enable}, 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_errors", {30'd0, i_error, d_error}, 32'd0);
    chk("rst_i_data_out", i_data_out, 32'd0);
    chk("rst_d_data_out", d_data_out, 32'd0);

    vecs[0] = '{1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h10, 4'hF, 32'h0,        0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 4'hF, 32'hFFFFFFFF, 0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 4'h3, 32'h12345678, 0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h20, 4'hF, 32'h0,        0, 32'hFFFF5678};
    vecs[5] = '{1'b0, 1'b1, 32'h10, 4'hF, 32'h0,        1, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b1, 32'h10, 4'hF, 32'h0,        5, 32'hDEADBEEF};
    vecs[7] = '{1'b0, 1'b0, 32'h20, 4'hC, 32'hCAFEF00D, 1, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 1'b1, 32'h20, 4'hF, 32'h0,        0, 32'hCAFE5678};
    for (int v = 0; v < 9; v++) begin
      mem_lat = vecs[v].lat;
      access(vecs[v].p, vecs[v].rw, vecs[v].addr, vecs[v].be, vecs[v].wd, 3 + vecs[v].lat, 1'b0);
      chk("vec_data_out", vecs[v].p ? d_data_out : i_data_out, vecs[v].exp_out);
    end
    mem_lat = 0;

    // both ports held after reset: D wins the first tie, then strict alternation
    reset = 1; tick(); tick(); reset = 0;
    last_g = 0; hold[0] = '0; hold[1] = '0;
    f_rw[0] = 1; f_addr[0] = 32'h10; f_rw[1] = 1; f_addr[1] = 32'h20;
    drive(0, 1); drive(1, 1);
    exp_p = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0; got = 0;
      while (!got && n < 30) begin tick(); n++; if (i_ack || d_ack) got = 1; end
      if (k == 3) begin drive(0, 0); drive(1, 0); end
      chk("tie_ack_seen", {31'd0, got}, 32'd1);
      if (got) chk("tie_winner", {31'd0, d_ack}, {31'd0, exp_p});
      model_done(exp_p, 0);
      chk("tie_data", exp_p ? d_data_out : i_data_out, hold[exp_p]);
      exp_p = ~exp_p;
    end
    tick();

    stuck = 1;
    access(1, 1, 32'h10, 4'hF, 32'h0, 2 + TO, 1'b1);
    chk("timeout_enable_low", {31'd0, mem_enable}, 32'd0);
    stuck = 0;

    // reset while the strobe is outstanding
    stuck = 1;
    f_rw[0] = 1; f_addr[0] = 32'h10;
    drive(0, 1);
    repeat (4) tick();
    chk("midrst_in_strobe", {31'd0, mem_enable}, 32'd1);
    reset = 1; drive(0, 0);
    tick();
    chk("midrst_enable", {31'd0, mem_enable}, 32'd0);
    chk("midrst_ack", {30'd0, i_ack, d_ack}, 32'd0);
    reset = 0; last_g = 0; hold[0] = '0; hold[1] = '0;
    seen = 0;
    repeat (10) begin tick(); if (i_ack || d_ack || mem_enable) seen = 1; end
    chk("midrst_quiet", {31'd0, seen}, 32'd0);
    stuck = 0;
    access(0, 1, 32'h10, 4'hF, 32'h0, 3, 1'b0);

    for (int it = 0; it < 40; it++) begin
      m = $urandom_range(1, 3);
      for (int q = 0; q < 2; q++) begin
        f_rw[q]   = 1'($urandom_range(0, 1));
        f_addr[q] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        f_be[q]   = 4'($urandom);
        f_wd[q]   = $urandom;
      end
      mem_lat = $urandom_range(0, 2);
      nacc  = (m == 3) ? 2 : 1;
      exp_p = (m == 3) ? ~last_g : (m == 2);
      if (m[0]) drive(0, 1);
      if (m[1]) drive(1, 1);
      for (int k = 0; k < nacc; k++) begin
        n = 0; got = 0;
        while (!got && n < 30) begin tick(); n++; if (i_ack || d_ack) got = 1; end
        drive(exp_p, 0);
        chk("rand_ack_seen", {31'd0, got}, 32'd1);
        if (got) chk("rand_winner", {31'd0, d_ack}, {31'd0, exp_p});
        chk("rand_error", {31'd0, exp_p ? d_error : i_error}, 32'd0);
        model_done(exp_p, 0);
        chk("rand_data", exp_p ? d_data_out : i_data_out, hold[exp_p]);
        exp_p = ~exp_p;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
